// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared definitions for the CNN datapath stages: data width,
//                tile-engine state encoding and the accumulator saturation
//                helper that narrows a wide signed sum to DATA_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int DATA_W   = 32;

    // Width of the saturate() argument. Any accumulator up to this width is
    // sign-extended into it by the caller, so the helper is width-agnostic.
    localparam int SAT_IN_W = 128;

    localparam logic signed [SAT_IN_W-1:0] SAT_MAX =
        {{(SAT_IN_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN =
        {{(SAT_IN_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Clamp a wide signed value to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    function automatic logic [DATA_W-1:0] saturate(input logic signed [SAT_IN_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DATA_W-1:0];
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_mac_engine_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mac_unit
//  Description : Registered signed DATA_W x DATA_W multiply-accumulate.
//                The full 2*DATA_W-bit product is sign-extended into an
//                ACC_W-bit accumulator. Clear has priority over enable.
//  Ports       : clk, rst_n   - clock, synchronous active-low reset
//                i_clear      - zero the accumulator
//                i_en         - add i_a * i_b to the accumulator
//                i_a, i_b     - signed operands
//                o_acc        - accumulator value (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_unit
    import cnn_pkg::*;
#(
    parameter int ACC_W = 68
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    r_acc;

    // Both operands signed, so they are sign-extended to the 64-bit context.
    assign w_prod = i_a * i_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/tile_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tile_mac_engine
//  Description : Sequential convolution stage behind the image tiler. On
//                start it captures all tiles and the kernel, then for each
//                tile accumulates the element-wise product (one MAC per
//                cycle, row-major) and streams one saturated 32-bit result
//                per tile over a valid/ready handshake.
//  Ports       : clk, rst_n   - clock, synchronous active-low reset
//                start        - begin a pass (sampled only in IDLE)
//                tiles        - N_TILES x F x F signed pixel tiles
//                kernel       - F x F signed weights
//                busy         - high in every state except IDLE
//                out_valid    - result available
//                out_ready    - downstream accepts the result
//                out_data     - saturated tile sum
//                out_idx      - tile index of out_data
//                done         - one-cycle pulse after the last handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_mac_engine
    import cnn_pkg::*;
#(
    parameter  int SIZE        = 9,
    parameter  int FILTER_SIZE = 3,
    localparam int N_TILES     = (SIZE / FILTER_SIZE) * (SIZE / FILTER_SIZE),
    localparam int K           = FILTER_SIZE * FILTER_SIZE,
    localparam int IDX_W       = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tiles  [0:N_TILES-1][0:FILTER_SIZE-1][0:FILTER_SIZE-1],
    input  logic [DATA_W-1:0] kernel [0:FILTER_SIZE-1][0:FILTER_SIZE-1],
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              done
);

    localparam int ROW_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int ACC_W = 2 * DATA_W + $clog2(K);

    localparam logic [ROW_W-1:0] LAST_RC = ROW_W'(FILTER_SIZE - 1);
    localparam logic [IDX_W-1:0] LAST_T  = IDX_W'(N_TILES - 1);

    state_e r_state;
    state_e w_next;

    logic [DATA_W-1:0] r_tiles  [0:N_TILES-1][0:FILTER_SIZE-1][0:FILTER_SIZE-1];
    logic [DATA_W-1:0] r_kernel [0:FILTER_SIZE-1][0:FILTER_SIZE-1];

    // Element counter e is kept split as (row, col) so no divider is needed.
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] r_col;
    logic [IDX_W-1:0] r_t;

    logic w_capture;
    logic w_clear;
    logic w_mac_en;
    logic w_last_el;
    logic w_handshake;

    logic signed [ACC_W-1:0] w_acc;

    assign w_last_el   = (r_row == LAST_RC) && (r_col == LAST_RC);
    assign w_handshake = (r_state == OUT) && out_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_clear   = 1'b0;
        w_mac_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture = 1'b1;
                    w_clear   = 1'b1;
                    w_next    = MAC;
                end
            end
            MAC: begin
                w_mac_en = 1'b1;
                if (w_last_el) begin
                    w_next = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    // Accumulator is cleared on the way back into MAC.
                    w_clear = 1'b1;
                    w_next  = (r_t == LAST_T) ? DONE : MAC;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_t   <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (w_capture) begin
            r_t   <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (w_mac_en) begin
            if (r_col == LAST_RC) begin
                r_col <= '0;
                r_row <= (r_row == LAST_RC) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else if (w_handshake && (r_t != LAST_T)) begin
            // Index stays on the last tile through DONE so out_idx never
            // points outside the tile array.
            r_t <= r_t + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Input capture: the pass runs entirely on these copies.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_tiles  <= tiles;
            r_kernel <= kernel;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    mac_unit #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_en    (w_mac_en),
        .i_a     ($signed(r_tiles[r_t][r_row][r_col])),
        .i_b     ($signed(r_kernel[r_row][r_col])),
        .o_acc   (w_acc)
    );

    // Accumulator is only touched in MAC, so in OUT it holds the tile sum
    // stable for as long as the handshake is stalled.
    assign out_data  = saturate(SAT_IN_W'(w_acc));
    assign out_idx   = r_t;
    assign out_valid = (r_state == OUT);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

endmodule
`default_nettype wire

// File: doc/tile_mac_engine.md
# tile_mac_engine

Sequential convolution stage directly downstream of the image tiler. It consumes the registered array of non-overlapping FILTER_SIZE×FILTER_SIZE tiles and one FILTER_SIZE×FILTER_SIZE kernel. For each tile it forms the element-wise product sum, one multiply-accumulate per cycle, and streams one saturated 32-bit result per tile, in tile order, over a valid/ready handshake.

## Interface
- SIZE, 9, image edge length in pixels
- FILTER_SIZE, 3, tile and kernel edge length; SIZE is an integer multiple of FILTER_SIZE
- Derived constants:
  - N_TILES = (SIZE/FILTER_SIZE)², number of tiles
  - K = FILTER_SIZE², elements per tile
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request a pass over all tiles; sampled only in IDLE
- tiles  in  [31:0] [0:N_TILES-1][0:FILTER_SIZE-1][0:FILTER_SIZE-1]  tile array, signed two's complement
- kernel  in  [31:0] [0:FILTER_SIZE-1][0:FILTER_SIZE-1]  weights, signed two's complement
- busy  out  1  high in every state except IDLE
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_data  out  32  signed saturated tile sum
- out_idx  out  $clog2(N_TILES)  index of the tile that out_data belongs to
- done  out  1  one-cycle pulse after the last result handshake

## Operation
- States and transitions:
  - IDLE: if start is high, go to MAC.
  - MAC: after K cycles, go to OUT.
  - OUT: on out_valid && out_ready, go to MAC if tiles remain; otherwise go to DONE.
  - DONE: after one cycle, go to IDLE.
- Capture:
  - On the start cycle, tiles and kernel are copied into internal registers.
  - Inputs may change freely afterwards. The whole pass uses the captured values.
- MAC:
  - The element counter e runs 0..K-1 in row-major order: row = e/FILTER_SIZE, col = e%FILTER_SIZE.
  - Each cycle: acc += tile[t][row][col] * kernel[row][col].
  - The product is a full 64-bit signed value. acc is signed, 64+$clog2(K) bits, and is cleared when entering MAC.
- OUT:
  - out_data = acc saturated to the range [-2^31, 2^31-1].
  - out_idx = t.
  - out_data and out_idx are held stable while out_valid && !out_ready.
- Tile order: t runs 0..N_TILES-1, which is the same order the tiler uses (row-major over tile positions).
- Start rules:
  - start while busy is ignored; there is no queueing.
  - start in the same cycle that DONE is active is ignored.
- Reset:
  - Every output resets to 0: busy, out_valid, out_data, out_idx, done.
  - State returns to IDLE and counters and acc clear.
  - Reset mid-pass discards all partial results; no done is emitted.

## Timing
- start sampled high at cycle T. MAC occupies cycles T+1..T+K. out_valid rises at T+K+1.
- With out_ready held high, each tile takes K+1 cycles. The full pass is N_TILES·(K+1) cycles after T; for the defaults that is 9·10 = 90.
- The handshake completes on a cycle where out_valid and out_ready are both high. The next tile's MAC begins the following cycle and out_valid drops in that same cycle.
- done is high for exactly one cycle: the cycle after the final handshake. busy is still high in that cycle and falls the cycle after.
- out_ready high while out_valid is low has no effect.

## Structure
- Shared package cnn_pkg holds:
  - DATA_W = 32
  - the state enum (IDLE, MAC, OUT, DONE)
  - the saturate function (acc → 32-bit signed)
- One sub-module, mac_unit: a registered signed 32×32 multiply-accumulate with a clear input. The top holds the FSM, counters, capture registers and handshake.

## Test plan
- All pixels = 1 and all weights = 1, out_ready tied high → nine results of 9 with out_idx 0..8; first out_valid at T+10; done at T+91.
- Kernel with centre = 1 and all others 0; pixel value = 10·row + col of the original image → each result equals the tile-centre pixel (e.g. tile 0 → 11, tile 8 → 77).
- out_ready low for 5 cycles on tile 3 → out_data and out_idx are held stable; no tile skipped or duplicated; total pass length grows by 5 cycles.
- Saturation:
  - all pixels 0x7FFFFFFF, all weights 0x7FFFFFFF → every out_data = 0x7FFFFFFF
  - weights 0x80000000 with the same pixels → every out_data = 0x80000000
- Change tiles and kernel one cycle after start → results match the captured values; start pulses during busy produce no extra results.
- Assert rst_n low during MAC of tile 4 → all outputs are 0 the next cycle and no done pulse; a fresh start then yields the complete 9-result pass.
